// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Handles signed and unsigned multiply and divide. Each operation takes WIDTH iterations,
// followed by one sign-fix cycle.
//
// Parameters:
//   WIDTH - operand width and HI/LO width (even, >= 4)
//   CNT_W - iteration counter width (2**CNT_W > WIDTH)
//
// Ports:
//   clk   - clock; all state changes on the rising edge
//   reset - synchronous, active-high reset
//   start - request a new operation; sampled only when idle
//   op    - operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b  - operands (multiplicand/multiplier or dividend/divisor)
//   busy  - high while an accepted operation is in progress
//   done  - one-cycle pulse when hi/lo hold a new result
//   div0  - one-cycle pulse on divide by zero; hi/lo are left unchanged
//   hi    - high product word or remainder
//   lo    - low product word or quotient
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {StIdle, StMulRun, StDivRun, StFix, StZero} state_e;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Magnitude of the multiplicand or of the divisor.
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;  // negate product, or negate quotient
  logic                 neg_hi_q, neg_hi_d;  // negate remainder (divide only)
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand magnitudes and signs at acceptance.
  logic                 op_signed, sign_a, sign_b;
  logic [WIDTH-1:0]     a_mag, b_mag;

  assign op_signed = ~op[0];
  assign sign_a    = op_signed & a[WIDTH-1];
  assign sign_b    = op_signed & b[WIDTH-1];
  assign a_mag     = sign_a ? (-a) : a;
  assign b_mag     = sign_b ? (-b) : b;

  // Shift-add step: add the multiplicand to the upper half when the current multiplier bit is
  // set. The carry is kept in the extra bit, then everything shifts right by one.
  logic [WIDTH:0]       mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Restoring step: shift in the next dividend bit, then subtract if the divisor fits.
  // When it fits, the difference is below the divisor and so fits in WIDTH bits.
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_rem   = div_shift[WIDTH-1:0] - opb_q;

  logic [2*WIDTH-1:0]   prod_fix;
  assign prod_fix = neg_lo_q ? (-acc_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          busy_d   = 1'b1;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_lo_d = sign_a ^ sign_b;
          neg_hi_d = sign_a;
          if (op[1]) begin
            opb_d = b_mag;
            acc_d = {{WIDTH{1'b0}}, a_mag};
            state_d = (b == '0) ? StZero : StDivRun;
          end else begin
            opb_d   = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            state_d = StMulRun;
          end
        end
      end

      StMulRun: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastIter) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end

      StDivRun: begin
        acc_d = {(div_ge ? div_rem : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastIter) begin
          cnt_d   = '0;
          state_d = StFix;
        end
      end

      StFix: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          hi_d = neg_hi_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      StZero: begin
        div0_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
